// File: rtl/misc_pkg.sv
// Shared constants for the misc register block and its Wishbone poller:
// register addresses, record magic and poller state encodings.
package misc_pkg;

  localparam logic [7:0] MISC_ADDR_BOOT = 8'h00;
  localparam logic [7:0] MISC_ADDR_E1_0 = 8'h04;
  localparam logic [7:0] MISC_ADDR_E1_1 = 8'h05;
  localparam logic [7:0] MISC_ADDR_TIME = 8'h07;

  localparam logic [7:0] REC_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_GAP,
    ST_EMIT
  } poll_state_t;

endpackage

// File: rtl/misc_poller.sv
// Wishbone initiator that reads the two E1 capture counters and the time counter
// on each trigger and streams them out as a 4-word record.
module misc_poller
  import misc_pkg::*;
#(
  parameter logic [7:0] ADDR_E1_0 = MISC_ADDR_E1_0,
  parameter logic [7:0] ADDR_E1_1 = MISC_ADDR_E1_1,
  parameter logic [7:0] ADDR_TIME = MISC_ADDR_TIME,
  parameter int         TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  output logic [7:0]  wb_addr,
  output logic [31:0] wb_wdata,
  output logic        wb_we,
  output logic        wb_cyc,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  poll_state_t r_state, w_stateNext;
  logic [1:0]  r_idx, w_idxNext;
  logic [1:0]  r_wordIdx;
  logic [7:0]  r_toCnt;
  logic [2:0]  r_toFlag, w_toFlagNext;
  logic [7:0]  r_seq, r_drops, r_hdrDrops;
  logic [31:0] r_buf0, r_buf1, r_buf2;
  logic        r_cyc, r_valid, r_outLast;
  logic [7:0]  r_addr;
  logic [31:0] r_outData;
  logic        w_hs, w_accept, w_rdDone, w_timedOut;
  logic [31:0] w_rdWord, w_hdrWord;

  function automatic logic [7:0] addrOf(input logic [1:0] idx);
    case (idx)
      2'd0:    return ADDR_E1_0;
      2'd1:    return ADDR_E1_1;
      default: return ADDR_TIME;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  // The last read goes straight to EMIT: its cyc-low cycle is the first valid cycle.
  always_comb begin
    w_stateNext  = r_state;
    w_idxNext    = r_idx;
    w_accept     = 1'b0;
    w_rdDone     = 1'b0;
    w_timedOut   = 1'b0;
    w_toFlagNext = r_toFlag;
    w_hs         = r_valid & out_ready;
    unique case (r_state)
      ST_IDLE: begin
        if (trig) begin
          w_accept     = 1'b1;
          w_idxNext    = 2'd0;
          w_toFlagNext = 3'b000;
          w_stateNext  = ST_RD;
        end
      end
      ST_RD: begin
        w_timedOut = ~wb_ack & (r_toCnt == TIMEOUT_M1);
        w_rdDone   = wb_ack | w_timedOut;
        if (w_timedOut) w_toFlagNext = r_toFlag | 3'(3'b001 << r_idx);
        if (w_rdDone) w_stateNext = (r_idx == 2'd2) ? ST_EMIT : ST_GAP;
      end
      ST_GAP: begin
        w_idxNext   = r_idx + 2'd1;
        w_stateNext = ST_RD;
      end
      ST_EMIT: begin
        if (w_hs && r_wordIdx == 2'd3) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign w_rdWord  = w_timedOut ? 32'hFFFF_FFFF : wb_rdata;
  assign w_hdrWord = {REC_MAGIC, 5'b0, w_toFlagNext, r_seq, r_hdrDrops};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= 2'd0;
      r_wordIdx  <= 2'd0;
      r_toCnt    <= 8'd0;
      r_toFlag   <= 3'b000;
      r_seq      <= 8'd0;
      r_drops    <= 8'd0;
      r_hdrDrops <= 8'd0;
      r_buf0     <= 32'd0;
      r_buf1     <= 32'd0;
      r_buf2     <= 32'd0;
      r_cyc      <= 1'b0;
      r_addr     <= ADDR_E1_0;
      r_valid    <= 1'b0;
      r_outData  <= 32'd0;
      r_outLast  <= 1'b0;
    end else begin
      r_idx    <= w_idxNext;
      r_toFlag <= w_toFlagNext;
      r_cyc    <= (w_stateNext == ST_RD);
      r_addr   <= addrOf(w_idxNext);
      r_valid  <= (w_stateNext == ST_EMIT);

      if (w_accept) begin
        r_hdrDrops <= r_drops;
        r_drops    <= 8'd0;
      end else if (trig && r_state != ST_IDLE && r_drops != 8'hFF) begin
        r_drops <= r_drops + 8'd1;
      end

      if (r_state == ST_RD && !w_rdDone) r_toCnt <= r_toCnt + 8'd1;
      else                               r_toCnt <= 8'd0;

      if (w_rdDone) begin
        case (r_idx)
          2'd0:    r_buf0 <= w_rdWord;
          2'd1:    r_buf1 <= w_rdWord;
          default: r_buf2 <= w_rdWord;
        endcase
      end

      // Output word k+1 comes from buffer k; the header is built on entry to EMIT.
      if (r_state == ST_RD && w_stateNext == ST_EMIT) begin
        r_outData <= w_hdrWord;
        r_outLast <= 1'b0;
        r_wordIdx <= 2'd0;
      end else if (w_hs) begin
        if (r_wordIdx == 2'd3) begin
          r_seq     <= r_seq + 8'd1;
          r_outData <= 32'd0;
          r_outLast <= 1'b0;
        end else begin
          r_wordIdx <= r_wordIdx + 2'd1;
          r_outLast <= (r_wordIdx == 2'd2);
          case (r_wordIdx)
            2'd0:    r_outData <= r_buf0;
            2'd1:    r_outData <= r_buf1;
            default: r_outData <= r_buf2;
          endcase
        end
      end
    end
  end

  assign wb_cyc    = r_cyc;
  assign wb_addr   = r_addr;
  assign wb_we     = 1'b0;
  assign wb_wdata  = 32'd0;
  assign out_valid = r_valid;
  assign out_data  = r_outData;
  assign out_last  = r_outLast;

endmodule

// File: tb/tb_misc_poller.sv
// Self-checking bench for misc_poller: a transaction-level record model driven by
// directed and randomized triggers, responder latencies and stream back-pressure.
module tb_misc_poller;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we, wb_cyc;
  logic [31:0] wb_rdata = 32'd0;
  logic        wb_ack = 1'b0;
  logic [31:0] out_data;
  logic        out_last, out_valid;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  misc_poller #(.ADDR_E1_0(8'h04), .ADDR_E1_1(8'h05), .ADDR_TIME(8'h07), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .trig(trig),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_rdata(wb_rdata), .wb_ack(wb_ack),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  int nVec = 0, nMis = 0;
  bit checkEn = 0;

  // responder configuration
  logic [31:0] regVal [3];
  int          ackLat = 1;
  logic [7:0]  noAckAddr = 8'hFF;
  bit          strayAcks = 0;
  int          rCnt = 0;

  // record-level model: one in-flight read plus a queue of words awaiting the stream
  bit          mCyc, mGap;
  int          mRead, mAge;
  logic [31:0] mWords [3];
  logic [2:0]  mTo;
  logic [7:0]  mSeq, mDrops, mHdrDrops;
  logic [31:0] mQ [$];

  logic [31:0] rec [4];
  int          cycNum = 0, trigCycle = -100, cyc5Cnt = 0;
  logic [15:0] cycMask, validMask;

  function automatic logic [7:0] addrOf(int i);
    case (i)
      0:       return 8'h04;
      1:       return 8'h05;
      default: return 8'h07;
    endcase
  endfunction

  function automatic bit modelIdle();
    return !mCyc && !mGap && mQ.size() == 0;
  endfunction

  function automatic logic pickReady(int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return cycNum[0];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mCyc = 0; mGap = 0; mRead = 0; mAge = 0; mTo = 3'b000;
    mSeq = 8'd0; mDrops = 8'd0; mHdrDrops = 8'd0;
    mQ.delete();
  endtask

  task automatic checkOutput();
    int off;
    if (!checkEn) return;
    check("wb_cyc", wb_cyc, mCyc);
    check("out_valid", out_valid, mQ.size() != 0);
    check("wb_we", wb_we, 0);
    check("wb_wdata", wb_wdata, 0);
    if (mCyc) check("wb_addr", wb_addr, addrOf(mRead));
    if (mQ.size() != 0) begin
      check("out_data", out_data, mQ[0]);
      check("out_last", out_last, mQ.size() == 1);
    end
    off = cycNum - trigCycle;
    if (off >= 1 && off < 16) begin
      cycMask[off]   = wb_cyc;
      validMask[off] = out_valid;
    end
    if (wb_cyc === 1'b1 && wb_addr == 8'h05) cyc5Cnt++;
  endtask

  task automatic respond();
    if (wb_cyc === 1'b1) rCnt++;
    else                 rCnt = 0;
    if (wb_cyc === 1'b1 && rCnt > ackLat && wb_addr != noAckAddr) begin
      wb_ack = 1'b1;
      case (wb_addr)
        8'h04:   wb_rdata = regVal[0];
        8'h05:   wb_rdata = regVal[1];
        8'h07:   wb_rdata = regVal[2];
        default: wb_rdata = $urandom;
      endcase
    end else begin
      wb_ack   = strayAcks && wb_cyc !== 1'b1 && ($urandom_range(0, 3) == 0);
      wb_rdata = $urandom;
    end
  endtask

  task automatic modelStep();
    bit hs, accept, done;
    logic [31:0] d;
    hs = (mQ.size() != 0) && out_ready;
    accept = trig && modelIdle();
    if (hs) rec[4 - mQ.size()] = out_data;
    if (trig && !accept && mDrops != 8'hFF) mDrops++;
    if (mCyc) begin
      mAge++;
      done = 0;
      d = 32'd0;
      if (wb_ack) begin
        d = wb_rdata; done = 1;
      end else if (mAge == TIMEOUT) begin
        d = 32'hFFFF_FFFF; mTo[mRead] = 1'b1; done = 1;
      end
      if (done) begin
        mWords[mRead] = d;
        mCyc = 0;
        if (mRead == 2) begin
          mQ.push_back({8'hA5, 5'b0, mTo, mSeq, mHdrDrops});
          for (int k = 0; k < 3; k++) mQ.push_back(mWords[k]);
        end else mGap = 1;
      end
    end else if (mGap) begin
      mGap = 0; mRead++; mCyc = 1; mAge = 0;
    end
    if (hs) begin
      void'(mQ.pop_front());
      if (mQ.size() == 0) mSeq++;
    end
    if (accept) begin
      mHdrDrops = mDrops; mDrops = 8'd0; mTo = 3'b000;
      mRead = 0; mAge = 0; mCyc = 1;
    end
  endtask

  // Called at a falling edge: check this cycle's outputs, drive its inputs, advance the model.
  task automatic applyStimulus(input logic t, input logic rdy, input logic r = 1'b0);
    checkOutput();
    trig = t;
    out_ready = rdy;
    rst = r;
    respond();
    if (r) modelReset();
    else   modelStep();
    cycNum++;
    @(negedge clk);
  endtask

  task automatic runRecord(input int readyMode);
    int n = 0;
    trigCycle = cycNum;
    applyStimulus(1'b1, pickReady(readyMode));
    while (!modelIdle() && n < 300) begin
      applyStimulus(1'b0, pickReady(readyMode));
      n++;
    end
    if (!modelIdle()) begin
      nVec++; nMis++;
      $display("[TB] FAIL runRecord: record still busy after %0d cycles, expected idle", n);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] w0;
    int n;
    modelReset();
    regVal = '{32'h0000_1234, 32'h0000_0ABC, 32'h0010_0000};
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("reset wb_cyc", wb_cyc, 0);
    check("reset wb_addr", wb_addr, 8'h04);
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset out_data", out_data, 0);
    checkEn = 1;

    $display("[TB] basic record, one-cycle ack");
    cycMask = '0; validMask = '0;
    runRecord(0);
    check("cyc windows", cycMask, 16'h01B6);
    check("valid window", validMask, 16'h1E00);
    check("rec0 word0", rec[0], 32'hA500_0000);
    check("rec0 word1", rec[1], 32'h0000_1234);
    check("rec0 word2", rec[2], 32'h0000_0ABC);
    check("rec0 word3", rec[3], 32'h0010_0000);

    $display("[TB] toggling ready");
    runRecord(1);
    check("rec1 word0", rec[0], 32'hA500_0100);
    check("rec1 word3", rec[3], 32'h0010_0000);

    $display("[TB] timeout on link 1");
    noAckAddr = 8'h05; cyc5Cnt = 0;
    runRecord(0);
    check("timeout cyc length", cyc5Cnt, 15);
    check("timeout word2", rec[2], 32'hFFFF_FFFF);
    check("timeout word0", rec[0], 32'hA502_0200);
    noAckAddr = 8'hFF;
    runRecord(0);
    check("post-timeout word0", rec[0], 32'hA500_0300);
    check("post-timeout word2", rec[2], 32'h0000_0ABC);

    $display("[TB] drops incl. trig on word-3 handshake");
    trigCycle = cycNum;
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (!modelIdle() && n < 200) begin
      applyStimulus((n == 2) || (n == 5) || (mQ.size() == 1), 1'b1);
      n++;
    end
    runRecord(0);
    check("drops=3 word0", rec[0], 32'hA500_0503);
    runRecord(0);
    check("drops cleared word0", rec[0], 32'hA500_0600);

    $display("[TB] drop saturation");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!modelIdle() && n < 50) begin applyStimulus(1'b0, 1'b1); n++; end
    runRecord(0);
    check("saturated word0", rec[0], 32'hA500_08FF);
    runRecord(0);
    check("after saturation word0", rec[0], 32'hA500_0900);

    $display("[TB] randomized traffic");
    strayAcks = 1;
    for (int c = 0; c < 3000; c++) begin
      if (modelIdle()) begin
        ackLat = $urandom_range(0, 4);
        noAckAddr = ($urandom_range(0, 5) == 0) ? addrOf($urandom_range(0, 2)) : 8'hFF;
        for (int k = 0; k < 3; k++) regVal[k] = $urandom;
      end
      applyStimulus($urandom_range(0, 9) == 0, pickReady(2));
    end
    n = 0;
    while (!modelIdle() && n < 500) begin applyStimulus(1'b0, 1'b1); n++; end
    noAckAddr = 8'hFF; ackLat = 1;

    $display("[TB] sequence wrap");
    n = 0;
    while (modelIdle() && mSeq != 8'd255 && n < 300) begin runRecord(2); n++; end
    runRecord(0);
    w0 = rec[0];
    check("seq 255", w0[15:8], 8'hFF);
    runRecord(0);
    w0 = rec[0];
    check("seq wrapped", w0[15:8], 8'h00);

    $display("[TB] reset during read");
    strayAcks = 0; ackLat = 3;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    check("midreset wb_cyc", wb_cyc, 0);
    check("midreset out_valid", out_valid, 0);
    applyStimulus(1'b0, 1'b1);
    ackLat = 1;
    regVal = '{32'h0000_1234, 32'h0000_0ABC, 32'h0010_0000};
    runRecord(0);
    check("fresh word0", rec[0], 32'hA500_0000);
    check("fresh word1", rec[1], 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
